// File: rtl/ltc_pkg.sv
// Shared constants, state encoding and field record for the LTC frame decoder.
// LTC bit positions are the on-tape positions of the forward-order frame.
package ltc_pkg;

    localparam int unsigned LTC_FRAME_BITS = 80;
    localparam int unsigned SYNC_BITS      = 16;
    localparam int unsigned SYNC_POS       = 64;
    localparam logic [15:0] SYNC_FWD       = 16'hBFFC;
    localparam logic [15:0] SYNC_REV       = 16'h3FFD;

    localparam int unsigned FRM_UNITS_POS   = 0;
    localparam int unsigned FRM_TENS_POS    = 8;
    localparam int unsigned DROP_FRAME_POS  = 10;
    localparam int unsigned COLOR_FRAME_POS = 11;
    localparam int unsigned SEC_UNITS_POS   = 16;
    localparam int unsigned SEC_TENS_POS    = 24;
    localparam int unsigned MIN_UNITS_POS   = 32;
    localparam int unsigned MIN_TENS_POS    = 40;
    localparam int unsigned HRS_UNITS_POS   = 48;
    localparam int unsigned HRS_TENS_POS    = 56;
    localparam int unsigned USER_POS        = 4;
    localparam int unsigned USER_STRIDE     = 8;
    localparam int unsigned USER_GROUPS     = 8;

    typedef enum logic {
        HUNT,
        LOCKED
    } ltc_state_t;

    typedef struct packed {
        logic [7:0]  hours;
        logic [7:0]  minutes;
        logic [7:0]  seconds;
        logic [7:0]  frames;
        logic [31:0] user_bits;
        logic        drop_frame;
        logic        color_frame;
    } ltc_tc_t;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/ltc_field_extract.sv
// Combinational decode of the 80-bit frame window into BCD time fields, flags,
// user bits and a BCD validity flag, for either playback direction.
module ltc_field_extract
    import ltc_pkg::*;
(
    input  logic [LTC_FRAME_BITS-1:0] sr,
    input  logic                      reverse,
    output ltc_tc_t                   tc,
    output logic                      bcd_ok
);

    logic [LTC_FRAME_BITS-1:0] f;
    logic [3:0] frm_u, sec_u, min_u, hrs_u;
    logic [1:0] frm_t, hrs_t;
    logic [2:0] sec_t, min_t;
    logic       hrs_range_ok;
    logic       unused_f;

    // Reverse playback delivers the sync word after the data it belongs to, so
    // the 64 data bits sit below it in sr with LTC bit 0 next to the sync.
    always_comb begin
        f = sr;
        if (reverse) begin
            for (int k = 0; k < int'(SYNC_POS); k++) begin
                f[k] = sr[int'(SYNC_POS) - 1 - k];
            end
        end
    end

    assign frm_u = f[FRM_UNITS_POS +: 4];
    assign frm_t = f[FRM_TENS_POS  +: 2];
    assign sec_u = f[SEC_UNITS_POS +: 4];
    assign sec_t = f[SEC_TENS_POS  +: 3];
    assign min_u = f[MIN_UNITS_POS +: 4];
    assign min_t = f[MIN_TENS_POS  +: 3];
    assign hrs_u = f[HRS_UNITS_POS +: 4];
    assign hrs_t = f[HRS_TENS_POS  +: 2];

    always_comb begin
        tc             = '0;
        tc.frames      = {2'b00, frm_t, frm_u};
        tc.seconds     = {1'b0,  sec_t, sec_u};
        tc.minutes     = {1'b0,  min_t, min_u};
        tc.hours       = {2'b00, hrs_t, hrs_u};
        tc.drop_frame  = f[DROP_FRAME_POS];
        tc.color_frame = f[COLOR_FRAME_POS];
        for (int g = 0; g < int'(USER_GROUPS); g++) begin
            tc.user_bits[4*g +: 4] = f[int'(USER_POS) + int'(USER_STRIDE) * g +: 4];
        end
    end

    assign hrs_range_ok = !((hrs_t == 2'd2) && (hrs_u > 4'd3));

    always_comb begin
        bcd_ok = bcd_digit_ok(frm_u) && bcd_digit_ok(sec_u) &&
                 bcd_digit_ok(min_u) && bcd_digit_ok(hrs_u) &&
                 (frm_t <= 2'd2) && (sec_t <= 3'd5) && (min_t <= 3'd5) &&
                 (hrs_t <= 2'd2) && hrs_range_ok;
    end

    // Polarity/BGF flags and the sync word itself carry no decoded field.
    assign unused_f = ^{f[27], f[43], f[59:58], f[79:64]};

endmodule

// File: rtl/ltc_frame_decoder.sv
// LTC frame aligner: hunts for the sync word in either direction, locks to the
// 80-bit frame boundary and publishes validated timecode with a one-cycle strobe.
module ltc_frame_decoder
    import ltc_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_strobe,
    input  logic        bit_in,
    input  logic        nosignal,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        locked,
    output logic        reverse,
    output logic [7:0]  tc_hours,
    output logic [7:0]  tc_minutes,
    output logic [7:0]  tc_seconds,
    output logic [7:0]  tc_frames,
    output logic [31:0] user_bits,
    output logic        drop_frame,
    output logic        color_frame
);

    localparam logic [6:0] LAST_BIT  = 7'(LTC_FRAME_BITS - 1);
    localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);

    logic [LTC_FRAME_BITS-1:0] sr;
    logic                      strobe_q;
    ltc_state_t                state;
    logic [6:0]                bit_cnt;
    logic [2:0]                miss_cnt;
    ltc_tc_t                   tc_q;

    logic    fwd_match, rev_match, sync_hit, same_dir, frame_end, eval_rev;
    logic    accept, reject, miss;
    ltc_tc_t ext_tc;
    logic    bcd_ok;

    // Evaluation runs one cycle after the strobe, on the already-shifted window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            strobe_q <= 1'b0;
        end else if (nosignal) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= bit_strobe;
            if (bit_strobe) begin
                sr <= {bit_in, sr[LTC_FRAME_BITS-1:1]};
            end
        end
    end

    assign fwd_match = (sr[LTC_FRAME_BITS-1 -: SYNC_BITS] == SYNC_FWD);
    assign rev_match = (sr[LTC_FRAME_BITS-1 -: SYNC_BITS] == SYNC_REV);
    assign eval_rev  = (state == LOCKED) ? reverse : rev_match;

    ltc_field_extract u_extract (
        .sr      (sr),
        .reverse (eval_rev),
        .tc      (ext_tc),
        .bcd_ok  (bcd_ok)
    );

    always_comb begin
        sync_hit  = fwd_match | rev_match;
        same_dir  = reverse ? rev_match : fwd_match;
        frame_end = (bit_cnt == LAST_BIT);
        accept    = 1'b0;
        reject    = 1'b0;
        miss      = 1'b0;
        if (strobe_q && !nosignal) begin
            if (state == HUNT) begin
                accept = sync_hit & bcd_ok;
                reject = sync_hit & ~bcd_ok;
            end else if (frame_end) begin
                // An opposite-direction sync while locked counts as a miss.
                accept = same_dir & bcd_ok;
                reject = same_dir & ~bcd_ok;
                miss   = ~same_dir;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            locked      <= 1'b0;
            reverse     <= 1'b0;
            bit_cnt     <= '0;
            miss_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            tc_q        <= '0;
        end else if (nosignal) begin
            state       <= HUNT;
            locked      <= 1'b0;
            bit_cnt     <= '0;
            miss_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject | miss;
            if (accept) begin
                tc_q    <= ext_tc;
                reverse <= eval_rev;
            end
            unique case (state)
                HUNT: begin
                    if (accept) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        bit_cnt  <= '0;
                        miss_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (strobe_q) begin
                        bit_cnt <= frame_end ? 7'd0 : bit_cnt + 7'd1;
                    end
                    if (accept) begin
                        miss_cnt <= '0;
                    end else if (miss) begin
                        if (miss_cnt == MISS_LAST) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 3'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    assign tc_hours    = tc_q.hours;
    assign tc_minutes  = tc_q.minutes;
    assign tc_seconds  = tc_q.seconds;
    assign tc_frames   = tc_q.frames;
    assign user_bits   = tc_q.user_bits;
    assign drop_frame  = tc_q.drop_frame;
    assign color_frame = tc_q.color_frame;

endmodule

// File: tb/tb_ltc_frame_decoder.sv
// Scoreboard bench: a bit-window reference model predicts every frame pulse,
// and a monitor checks each pulse, its timing and the held outputs.
module tb_ltc_frame_decoder;

    localparam int unsigned MISS_LIMIT = 3;
    localparam logic [15:0] FWD_WORD = 16'hBFFC;
    localparam logic [15:0] REV_WORD = 16'h3FFD;

    logic        clk = 1'b0;
    logic        rst, bit_strobe, bit_in, nosignal;
    logic        frame_valid, frame_err, locked, reverse;
    logic [7:0]  tc_hours, tc_minutes, tc_seconds, tc_frames;
    logic [31:0] user_bits;
    logic        drop_frame, color_frame;

    ltc_frame_decoder #(.MISS_LIMIT(MISS_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_strobe  (bit_strobe),
        .bit_in      (bit_in),
        .nosignal    (nosignal),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .reverse     (reverse),
        .tc_hours    (tc_hours),
        .tc_minutes  (tc_minutes),
        .tc_seconds  (tc_seconds),
        .tc_frames   (tc_frames),
        .user_bits   (user_bits),
        .drop_frame  (drop_frame),
        .color_frame (color_frame)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: last 80 received bits (newest at [79]) plus lock bookkeeping.
    typedef struct {
        bit          is_valid;
        int unsigned cyc;
        logic [7:0]  h, m, s, f;
        logic [31:0] ub;
        logic        df, cf, rev, lck;
    } exp_t;

    exp_t        expq[$];
    logic [79:0] win = '0;
    bit          m_locked = 0, m_rev = 0, m_rev_out = 0;
    int unsigned m_since = 0, m_miss = 0;
    logic [7:0]  m_h = 0, m_m = 0, m_s = 0, m_f = 0;
    logic [31:0] m_ub = 0;
    logic        m_df = 0, m_cf = 0;

    // LTC bit k of the frame held in the window for the given direction.
    function automatic int unsigned fld(input logic [79:0] w, input bit rv,
                                        input int unsigned pos, input int unsigned n);
        int unsigned v, k;
        v = 0;
        for (int i = 0; i < int'(n); i++) begin
            k = pos + i;
            if ((rv ? w[63 - k] : w[k]) == 1'b1) v += (1 << i);
        end
        return v;
    endfunction

    task automatic push_event(input bit is_valid, input int unsigned sc);
        exp_t e;
        e.is_valid = is_valid; e.cyc = sc;
        e.h = m_h; e.m = m_m; e.s = m_s; e.f = m_f; e.ub = m_ub;
        e.df = m_df; e.cf = m_cf; e.rev = m_rev_out; e.lck = m_locked;
        expq.push_back(e);
    endtask

    // Returns 1 and updates the held outputs when the window decodes to legal time.
    function automatic bit try_accept(input bit rv);
        int unsigned fu, ft, su, st, mu, mt, hu, ht;
        fu = fld(win, rv, 0, 4);  ft = fld(win, rv, 8, 2);
        su = fld(win, rv, 16, 4); st = fld(win, rv, 24, 3);
        mu = fld(win, rv, 32, 4); mt = fld(win, rv, 40, 3);
        hu = fld(win, rv, 48, 4); ht = fld(win, rv, 56, 2);
        if (fu > 9 || su > 9 || mu > 9 || hu > 9 || ft > 2 || st > 5 || mt > 5 ||
            ht > 2 || ht * 10 + hu > 23) return 0;
        m_f = 8'(ft * 16 + fu); m_s = 8'(st * 16 + su);
        m_m = 8'(mt * 16 + mu); m_h = 8'(ht * 16 + hu);
        m_ub = '0;
        for (int g = 0; g < 8; g++) m_ub |= 32'(fld(win, rv, 4 + 8 * g, 4)) << (4 * g);
        m_df = (fld(win, rv, 10, 1) == 1);
        m_cf = (fld(win, rv, 11, 1) == 1);
        m_rev_out = rv;
        return 1;
    endfunction

    task automatic model_strobe(input logic b, input int unsigned sc);
        bit fwd, rv;
        win = {b, win[79:1]};
        fwd = (win[79:64] == FWD_WORD);
        rv  = (win[79:64] == REV_WORD);
        if (!m_locked) begin
            if (fwd || rv) begin
                if (try_accept(rv)) begin
                    m_locked = 1; m_rev = rv; m_since = 0; m_miss = 0;
                    push_event(1, sc);
                end else begin
                    push_event(0, sc);
                end
            end
        end else begin
            m_since++;
            if (m_since == 80) begin
                m_since = 0;
                if (m_rev ? rv : fwd) begin
                    if (try_accept(m_rev)) begin
                        m_miss = 0;
                        push_event(1, sc);
                    end else begin
                        push_event(0, sc);
                    end
                end else begin
                    m_miss++;
                    if (m_miss == MISS_LIMIT) begin
                        m_locked = 0; m_miss = 0;
                    end
                    push_event(0, sc);
                end
            end
        end
    endtask

    // Monitor: every pulse must match the next predicted event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                if (frame_valid && frame_err) chk("pulse_exclusive", 32'(frame_err), 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_kind", 32'(frame_valid), 32'(e.is_valid));
                    chk("pulse_cycle", cyc, e.cyc + 2);
                    chk("locked", 32'(locked), 32'(e.lck));
                    chk("reverse", 32'(reverse), 32'(e.rev));
                    chk("tc", {tc_hours, tc_minutes, tc_seconds, tc_frames},
                        {e.h, e.m, e.s, e.f});
                    chk("user_bits", user_bits, e.ub);
                    chk("flags", {30'd0, drop_frame, color_frame}, {30'd0, e.df, e.cf});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_strobe = 1'b1;
        bit_in     = b;
        model_strobe(b, cyc);
        @(negedge clk);
        bit_strobe = 1'b0;
        bit_in     = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic send_random(input int unsigned n);
        for (int i = 0; i < int'(n); i++) send_bit(1'($urandom));
    endtask

    function automatic logic [79:0] mk_frame(input int unsigned h, input int unsigned m,
                                             input int unsigned s, input int unsigned f,
                                             input logic [31:0] ub, input bit df, input bit cf);
        logic [79:0] fr;
        logic [15:0] sw;
        fr = '0;
        sw = FWD_WORD;
        fr[3:0]   = 4'(f % 10); fr[9:8]   = 2'(f / 10);
        fr[10]    = df;         fr[11]    = cf;
        fr[19:16] = 4'(s % 10); fr[26:24] = 3'(s / 10);
        fr[35:32] = 4'(m % 10); fr[42:40] = 3'(m / 10);
        fr[51:48] = 4'(h % 10); fr[57:56] = 2'(h / 10);
        for (int g = 0; g < 8; g++) fr[4 + 8 * g +: 4] = ub[4 * g +: 4];
        fr[79:64] = sw;
        return fr;
    endfunction

    // Reverse playback: data bits 63..0, then the sync word 79..64.
    task automatic send_frame(input logic [79:0] fr, input bit rv);
        if (!rv) begin
            for (int k = 0; k < 80; k++) send_bit(fr[k]);
        end else begin
            for (int k = 63; k >= 0; k--) send_bit(fr[k]);
            for (int k = 79; k >= 64; k--) send_bit(fr[k]);
        end
    endtask

    task automatic pulse_nosignal();
        @(negedge clk);
        nosignal   = 1'b1;
        bit_strobe = 1'b1;
        bit_in     = 1'($urandom);
        m_locked = 0; m_since = 0; m_miss = 0;
        @(posedge clk);
        #1;
        chk("nosignal_locked", 32'(locked), 32'd0);
        chk("nosignal_tc_hold", {tc_hours, tc_minutes, tc_seconds, tc_frames},
            {m_h, m_m, m_s, m_f});
        @(negedge clk);
        nosignal   = 1'b0;
        bit_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [79:0] fr_a, fr_bad;

    initial begin
        rst = 1'b1; bit_strobe = 1'b0; bit_in = 1'b0; nosignal = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        chk("rst_lock_rev", {30'd0, locked, reverse}, 32'd0);
        chk("rst_tc", {tc_hours, tc_minutes, tc_seconds, tc_frames}, 32'd0);
        chk("rst_user", user_bits, 32'd0);
        chk("rst_flags", {30'd0, drop_frame, color_frame}, 32'd0);
        rst = 1'b0;

        // Forward lock
        fr_a = mk_frame(12, 34, 56, 29, 32'h12345678, 1'b0, 1'b0);
        send_random(37);
        send_frame(fr_a, 1'b0);
        repeat (4) @(negedge clk);
        chk("t1_tc", {tc_hours, tc_minutes, tc_seconds, tc_frames}, 32'h12345629);
        chk("t1_user", user_bits, 32'h12345678);
        chk("t1_lock_rev", {30'd0, locked, reverse}, 32'd2);

        // Continuous run
        for (int i = 0; i < 3; i++) begin
            send_frame(mk_frame(0, 0, 0, i, $urandom, 1'b0, 1'(i)), 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("t2_frames", 32'(tc_frames), 32'h02);

        // Reverse playback
        pulse_nosignal();
        send_random(21);
        send_frame(fr_a, 1'b1);
        send_frame(fr_a, 1'b1);
        repeat (4) @(negedge clk);
        chk("t3_rev", {30'd0, locked, reverse}, 32'd3);
        chk("t3_tc", {tc_hours, tc_minutes, tc_seconds, tc_frames}, 32'h12345629);

        // Sync loss
        pulse_nosignal();
        send_random(13);
        send_frame(mk_frame(1, 2, 3, 4, $urandom, 1'b1, 1'b0), 1'b0);
        fr_bad = mk_frame(1, 2, 3, 5, $urandom, 1'b0, 1'b0);
        fr_bad[70] = ~fr_bad[70];
        send_frame(fr_bad, 1'b0);
        send_frame(mk_frame(1, 2, 3, 6, $urandom, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 3; i++) send_frame(fr_bad, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_unlocked", 32'(locked), 32'd0);

        // nosignal mid-frame
        send_frame(mk_frame(23, 59, 59, 24, $urandom, 1'b0, 1'b1), 1'b0);
        fr_bad = mk_frame(23, 59, 59, 25, $urandom, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) send_bit(fr_bad[k]);
        pulse_nosignal();
        send_frame(mk_frame(10, 20, 30, 11, $urandom, 1'b0, 1'b0), 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_relock", 32'(locked), 32'd1);

        // BCD error while locked
        fr_bad = mk_frame(10, 20, 30, 12, $urandom, 1'b0, 1'b0);
        fr_bad[3:0] = 4'hA;
        send_frame(fr_bad, 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_hold", {tc_hours, tc_minutes, tc_seconds, tc_frames}, 32'h10203011);
        chk("t6_locked", 32'(locked), 32'd1);

        // Randomised tail: legal frames with occasional corruption
        for (int i = 0; i < 8; i++) begin
            fr_a = mk_frame($urandom_range(0, 23), $urandom_range(0, 59),
                            $urandom_range(0, 59), $urandom_range(0, 29),
                            $urandom, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) fr_a[$urandom_range(64, 79)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) fr_a[57:56] = 2'd3;
            send_frame(fr_a, 1'b0);
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
